exit_argmax_ctrl: RTL
=====================

Name: exit_argmax_ctrl

Overview:
- Sequences the shared 8-input max/argmax unit for the early-exit classifier heads of the dynamic network.
- Accepts one 8-score vector per exit stage and holds it stable on the max unit while the unit runs.
- Captures the winning score and class, compares the score against a per-stage confidence threshold, and issues either an "exit" (classification done) or a "continue" (run the next network stage) decision downstream.

Parameters:
- featureWidth, 16, signed score width; must match the max unit.
- NUM_EXITS, 4, number of exit stages; stage index width is SW = clog2(NUM_EXITS).
- TIMEOUT, 16, RUN cycles allowed before the run is declared failed; must be ≥ 12.
- THR_RESET, 16'sh4000, reset value of every stage threshold.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  score vector valid
- s_ready  out  1  controller can accept a vector
- s_scores  in  8*featureWidth  score k at bits [k*fW +: fW], k=0..7
- s_stage  in  SW  exit stage producing the scores
- mx_enable  out  1  enable to max unit
- mx_x  out  8*featureWidth  registered scores to max unit (x_1 = k0)
- mx_outvalid  in  1  max unit result strobe
- mx_max  in  featureWidth  max unit winning score
- mx_index  in  3  max unit winning index 0..7
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  SW  stage to write
- cfg_data  in  featureWidth  signed threshold
- o_valid  out  1  decision valid
- o_ready  in  1  downstream accepts decision
- o_exit  out  1  1 = classify now, 0 = continue to next stage
- o_class  out  3  winning class
- o_score  out  featureWidth  winning score
- o_stage  out  SW  stage of this decision
- o_error  out  1  run timed out; class/score invalid
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset values: state = IDLE; s_ready = 1; mx_enable = 0; mx_x = 0; o_valid = 0; o_exit = 0; o_class = 0; o_score = 0; o_stage = 0; o_error = 0; busy = 0; all thresholds = THR_RESET.
- Reset taken mid-run drops mx_enable the same edge. The max unit reinitialises when enable is low.
- FSM: IDLE → RUN → DECIDE → OUT → IDLE.
- IDLE:
  - s_ready = 1.
  - On s_valid: capture s_scores into mx_x and s_stage into a stage register, clear the timeout counter, go to RUN.
- RUN:
  - mx_enable = 1; mx_x held constant; timeout counter increments each cycle.
  - On mx_outvalid: capture mx_max and mx_index, go to DECIDE. mx_enable is low from the next cycle, which returns the max unit to its initial state.
  - If the counter reaches TIMEOUT-1 without mx_outvalid: set o_error = 1, o_exit = 1, o_class = 0, o_score = 0, go to OUT.
  - Nominal RUN length is 10 cycles (first enabled edge through outvalid).
- DECIDE (1 cycle):
  - exit = (captured max ≥ thr[stage], signed compare) OR (stage == NUM_EXITS-1).
  - Sentinel case: if captured max == most-negative value, the max unit never updated, so force o_class = 0.
  - Load the o_* registers, go to OUT.
- OUT:
  - o_valid = 1; all o_* held stable until o_ready.
  - On o_valid & o_ready: go to IDLE; o_valid and o_error clear the next cycle.
  - o_ready may be high before o_valid; the decision is then accepted on the first OUT cycle.
- Latency: s_valid accept to o_valid = 12 cycles nominal. There is no overlap; throughput is at most one vector per 12 + handshake cycles.
- Ties: the lowest index wins, because the max unit uses a strict greater-than compare.
- Thresholds:
  - cfg_we writes thr[cfg_addr] on the edge, in any state.
  - DECIDE reads the register value present that cycle; a write in the same cycle is not seen.
  - cfg_addr ≥ NUM_EXITS is ignored.
- s_stage ≥ NUM_EXITS is treated as the final stage (forced exit).
- s_valid while busy is not accepted (s_ready = 0) and must be held by the source.

Decomposition:
- Package exit_ctrl_pkg:
  - FSM state enum (IDLE, RUN, DECIDE, OUT).
  - NEG_SENTINEL constant (most-negative featureWidth value).
  - NOMINAL_LAT = 10.
- One sub-module, exit_thr_regfile: NUM_EXITS × featureWidth threshold registers with synchronous write and combinational read.
- The max unit is instantiated beside this block at top level, not inside it.

Test Plan:
- Stage 0, thr = 0x4000, scores {100, 0x5000, 3, -7, 0, 0x4FFF, 9, 1} → after 12 cycles: o_valid, o_class = 1, o_score = 0x5000, o_exit = 1, o_stage = 0.
- Stage 1, thr = 0x4000, max score 0x3FFF at index 6 → o_exit = 0, o_class = 6. Same vector sent as stage 3 → o_exit = 1 (forced final).
- Tie 0x2000 at indices 2 and 5 → o_class = 2. All scores = 0x8000 → o_class = 0, o_score = 0x8000.
- o_ready held low 20 cycles: o_* stable, s_ready = 0, a new s_valid is not accepted. Raise o_ready → IDLE the next cycle and the pending vector is accepted.
- Stub max unit never asserts outvalid → o_error = 1, o_exit = 1 after TIMEOUT cycles. Next vector with a real unit runs normally and o_error is cleared.
- Reset asserted in RUN cycle 5 → next cycle mx_enable = 0, o_valid = 0, s_ready = 1, thresholds = 0x4000. cfg write thr[2] = -5 in DECIDE of a stage-2 run → old value used; new value used on the next run.

Source files
------------

// File: rtl/exit_ctrl_pkg.sv
// Shared types and constants for the early-exit argmax controller.
package exit_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DECIDE = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam int unsigned FEATURE_WIDTH = 16;

  // Initial value held by the max unit before it sees any score.
  localparam logic signed [FEATURE_WIDTH-1:0] NEG_SENTINEL = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};

  localparam int unsigned NOMINAL_LAT = 10;

endpackage

// File: rtl/exit_thr_regfile.sv
// Per-stage confidence thresholds: synchronous write, combinational read.
module exit_thr_regfile #(
  parameter int unsigned featureWidth = 16,
  parameter int unsigned NUM_EXITS = 4,
  parameter int unsigned SW = 2,
  parameter logic signed [featureWidth-1:0] THR_RESET = 16'sh4000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_we,
  input  logic [SW-1:0]                  i_waddr,
  input  logic signed [featureWidth-1:0] i_wdata,
  input  logic [SW-1:0]                  i_raddr,
  output logic signed [featureWidth-1:0] o_rdata
);

  logic signed [featureWidth-1:0] r_thr [NUM_EXITS];

  // Addresses without a matching entry fall through: writes dropped, reads give THR_RESET.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_EXITS); i++) begin
        r_thr[i] <= THR_RESET;
      end
    end else begin
      for (int i = 0; i < int'(NUM_EXITS); i++) begin
        if (i_we && (i_waddr == SW'(i))) begin
          r_thr[i] <= i_wdata;
        end
      end
    end
  end

  always_comb begin
    o_rdata = THR_RESET;
    for (int i = 0; i < int'(NUM_EXITS); i++) begin
      if (i_raddr == SW'(i)) begin
        o_rdata = r_thr[i];
      end
    end
  end

endmodule

// File: rtl/exit_argmax_ctrl.sv
// Sequences the shared max/argmax unit for one early-exit head and issues exit/continue.
module exit_argmax_ctrl
  import exit_ctrl_pkg::*;
#(
  parameter int unsigned featureWidth = 16,
  parameter int unsigned NUM_EXITS = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter logic signed [featureWidth-1:0] THR_RESET = 16'sh4000,
  localparam int unsigned SW = (NUM_EXITS > 1) ? $clog2(NUM_EXITS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [8*featureWidth-1:0] s_scores,
  input  logic [SW-1:0]             s_stage,
  output logic                      mx_enable,
  output logic [8*featureWidth-1:0] mx_x,
  input  logic                      mx_outvalid,
  input  logic [featureWidth-1:0]   mx_max,
  input  logic [2:0]                mx_index,
  input  logic                      cfg_we,
  input  logic [SW-1:0]             cfg_addr,
  input  logic [featureWidth-1:0]   cfg_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      o_exit,
  output logic [2:0]                o_class,
  output logic [featureWidth-1:0]   o_score,
  output logic [SW-1:0]             o_stage,
  output logic                      o_error,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [featureWidth-1:0] NEG_VAL = {1'b1, {(featureWidth-1){1'b0}}};
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_EXITS - 1);

  state_e                         r_state;
  logic                           r_mx_enable;
  logic [8*featureWidth-1:0]      r_mx_x;
  logic [SW-1:0]                  r_stage;
  logic [CW-1:0]                  r_cnt;
  logic signed [featureWidth-1:0] r_max;
  logic [2:0]                     r_idx;
  logic                           r_o_valid;
  logic                           r_o_exit;
  logic [2:0]                     r_o_class;
  logic [featureWidth-1:0]        r_o_score;
  logic [SW-1:0]                  r_o_stage;
  logic                           r_o_error;

  logic signed [featureWidth-1:0] w_thr;
  logic                           w_final;
  logic                           w_exit;
  logic                           w_sentinel;

  exit_thr_regfile #(
    .featureWidth(featureWidth),
    .NUM_EXITS   (NUM_EXITS),
    .SW          (SW),
    .THR_RESET   (THR_RESET)
  ) u_thr (
    .clk    (clk),
    .reset  (reset),
    .i_we   (cfg_we),
    .i_waddr(cfg_addr),
    .i_wdata(cfg_data),
    .i_raddr(r_stage),
    .o_rdata(w_thr)
  );

  // Out-of-range stage indices count as the final head, which must always classify.
  assign w_final    = (r_stage >= STAGE_LAST);
  assign w_exit     = (r_max >= w_thr) || w_final;
  assign w_sentinel = (r_max == NEG_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mx_enable <= 1'b0;
      r_mx_x      <= '0;
      r_stage     <= '0;
      r_cnt       <= '0;
      r_max       <= '0;
      r_idx       <= '0;
      r_o_valid   <= 1'b0;
      r_o_exit    <= 1'b0;
      r_o_class   <= '0;
      r_o_score   <= '0;
      r_o_stage   <= '0;
      r_o_error   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_mx_x      <= s_scores;
            r_stage     <= s_stage;
            r_cnt       <= '0;
            r_mx_enable <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (mx_outvalid) begin
            r_max       <= mx_max;
            r_idx       <= mx_index;
            r_mx_enable <= 1'b0;
            r_state     <= DECIDE;
          end else if (r_cnt == CNT_LAST) begin
            r_mx_enable <= 1'b0;
            r_o_valid   <= 1'b1;
            r_o_error   <= 1'b1;
            r_o_exit    <= 1'b1;
            r_o_class   <= '0;
            r_o_score   <= '0;
            r_o_stage   <= r_stage;
            r_state     <= OUT;
          end
        end
        DECIDE: begin
          r_o_valid <= 1'b1;
          r_o_error <= 1'b0;
          r_o_exit  <= w_exit;
          r_o_class <= w_sentinel ? 3'd0 : r_idx;
          r_o_score <= r_max;
          r_o_stage <= r_stage;
          r_state   <= OUT;
        end
        OUT: begin
          if (o_ready) begin
            r_o_valid <= 1'b0;
            r_o_error <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign mx_enable = r_mx_enable;
  assign mx_x      = r_mx_x;
  assign o_valid   = r_o_valid;
  assign o_exit    = r_o_exit;
  assign o_class   = r_o_class;
  assign o_score   = r_o_score;
  assign o_stage   = r_o_stage;
  assign o_error   = r_o_error;

endmodule
